button_repeat_conditioner: RTL and testbench
============================================

// Module: button_repeat_conditioner
// PURPOSE
//   Per-button front end for the cursor path: 2-FF synchroniser, counter-based debouncer and
//   hold-to-repeat generator for the four board buttons (U,D,L,R). Outputs one-cycle press
//   pulses (initial press plus auto-repeats) that drive the cursor controller's button inputs
//   directly; any >=1-cycle pulse separated by low gaps is a distinct rising edge downstream.
// PARAMETERS
//   N_BTN            4           number of independent button channels
//   DEBOUNCE_CYCLES  1_000_000   cycles a synced input must differ from stable state to flip (10 ms @100 MHz)
//   REPEAT_DELAY     50_000_000  cycles from first pulse to first repeat pulse (500 ms)
//   REPEAT_RATE      10_000_000  cycles between consecutive repeat pulses (100 ms)
//   All >= 1; counters sized $clog2(max+1); elaboration error if any is 0.
// PORTS
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous, active-low reset
//   btn_in     in   N_BTN  raw async buttons, active-high, bit0=U bit1=D bit2=L bit3=R
//   repeat_en  in   1      1 = auto-repeat enabled; 0 = one pulse per press only
//   btn_level  out  N_BTN  debounced stable level per button
//   btn_pulse  out  N_BTN  one-cycle pulse: press and each repeat
// BEHAVIOUR
//   Reset (rst_n=0, async): sync FFs, stable levels, counters cleared; btn_level=0, btn_pulse=0,
//     all channels in IDLE. Release is synchronous to clk via the sync stage; no pulse out of reset.
//   Channels fully independent; simultaneous presses produce simultaneous pulses.
//   Sync: s = btn_in delayed 2 clk edges.
//   Debounce: db_cnt increments while s != btn_level, clears when s == btn_level; when
//     db_cnt reaches DEBOUNCE_CYCLES-1 and s still differs, btn_level <= s, db_cnt <= 0.
//     Glitch shorter than DEBOUNCE_CYCLES cycles: no level change, no pulse.
//     Latency: btn_level rises 2+DEBOUNCE_CYCLES edges after btn_in settles high.
//   Repeat FSM (per channel), timer rp_cnt:
//     IDLE  : on btn_level 0->1 -> btn_pulse=1 in the same cycle btn_level first reads 1;
//             go DELAY, rp_cnt=0.
//     DELAY : rp_cnt++ while repeat_en=1; at rp_cnt==REPEAT_DELAY-1 -> pulse, go REPEAT, rp_cnt=0.
//             repeat_en=0: rp_cnt held at 0, no pulses.
//     REPEAT: rp_cnt++; at rp_cnt==REPEAT_RATE-1 -> pulse, rp_cnt=0.
//             repeat_en 1->0: go DELAY, rp_cnt=0 (re-enable restarts full REPEAT_DELAY).
//     Any state, btn_level 1->0: go IDLE next cycle, rp_cnt=0, no pulse on release cycle.
//   Pulse spacing >= 2 cycles guaranteed only if REPEAT_RATE >= 2; with REPEAT_RATE=1 output
//     stays high (documented limitation, not a supported configuration).
//   btn_pulse registered; high exactly one cycle per event; never high while btn_level=0.
//   Mid-operation reset: outputs drop to 0 immediately; held button re-debounces after release
//     of rst_n and produces a fresh initial pulse.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, repeat_en=1)
//   1. btn_in[0] 0->1 held -> btn_level[0] rises 6 edges later, one pulse same cycle; repeat
//      pulses 20 cycles after, then every 8 cycles; other bits stay 0.
//   2. btn_in[2] high for 3 cycles then low (glitch) -> btn_level/btn_pulse[2] never assert.
//   3. Bouncing press: toggle btn_in[3] 1,0,1,0 each cycle then hold high -> exactly one
//      initial pulse, level rises 6 edges after final stable high.
//   4. repeat_en=0, hold btn_in[1] 100 cycles -> exactly one pulse; set repeat_en=1 ->
//      next pulse 20 cycles later.
//   5. Press U and R same cycle, release U after 30 cycles -> simultaneous first pulses;
//      U stops (level falls 6 edges after release), R keeps repeating every 8.
//   6. rst_n low for 1 cycle during REPEAT with button held -> outputs 0 asynchronously;
//      after release one new initial pulse at 6 edges, repeats resume per test 1 timing.

Source files
------------

// File: rtl/button_repeat_conditioner_if.sv
// Button bundle between the raw board buttons and the cursor controller:
// raw inputs and repeat enable in, debounced levels and press/repeat pulses out.
interface button_repeat_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic             repeat_en;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;

  modport master (
    output btn_in,
    output repeat_en,
    input  btn_level,
    input  btn_pulse
  );

  modport slave (
    input  btn_in,
    input  repeat_en,
    output btn_level,
    output btn_pulse
  );
endinterface

// File: rtl/button_repeat_conditioner.sv
// Per-button synchroniser, counter debouncer and hold-to-repeat pulse generator.
// Each channel emits a one-cycle pulse on press and on every auto-repeat.
module button_repeat_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  button_repeat_conditioner_if.slave  bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ZERO  = DB_W'(0);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [RP_W-1:0] RD_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RR_LAST  = RP_W'(REPEAT_RATE - 1);
  localparam logic [RP_W-1:0] RP_ZERO  = RP_W'(0);
  localparam logic [RP_W-1:0] RP_ONE   = RP_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  if (N_BTN < 1) begin : g_bad_nbtn
    $error("button_repeat_conditioner: N_BTN must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("button_repeat_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_rd
    $error("button_repeat_conditioner: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_RATE < 1) begin : g_bad_rr
    $error("button_repeat_conditioner: REPEAT_RATE must be >= 1");
  end

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;
  logic [N_BTN-1:0] level_vec_s;
  logic [N_BTN-1:0] pulse_vec_s;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {N_BTN{1'b0}};
      sync2_q <= {N_BTN{1'b0}};
    end else begin
      sync1_q <= bus.btn_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            level_q;
    logic            level_d;
    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [RP_W-1:0] rp_cnt_q;
    logic [RP_W-1:0] rp_cnt_d;
    logic            pulse_q;
    logic            pulse_d;
    logic            rise_s;
    logic            fall_s;

    // The stable level only flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      if (sync2_q[g] == level_q) begin
        db_cnt_d = DB_ZERO;
      end else if (db_cnt_q == DB_LAST) begin
        level_d  = sync2_q[g];
        db_cnt_d = DB_ZERO;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end

    assign rise_s = ~level_q & level_d;
    assign fall_s = level_q & ~level_d;

    // Release wins over everything so no pulse can coincide with a falling level.
    always_comb begin
      state_d  = state_q;
      rp_cnt_d = rp_cnt_q;
      pulse_d  = 1'b0;
      if (fall_s) begin
        state_d  = ST_IDLE;
        rp_cnt_d = RP_ZERO;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise_s) begin
              pulse_d  = 1'b1;
              state_d  = ST_DELAY;
              rp_cnt_d = RP_ZERO;
            end else begin
              rp_cnt_d = RP_ZERO;
            end
          end
          ST_DELAY: begin
            if (!bus.repeat_en) begin
              rp_cnt_d = RP_ZERO;
            end else if (rp_cnt_q == RD_LAST) begin
              pulse_d  = 1'b1;
              state_d  = ST_REPEAT;
              rp_cnt_d = RP_ZERO;
            end else begin
              rp_cnt_d = rp_cnt_q + RP_ONE;
            end
          end
          ST_REPEAT: begin
            if (!bus.repeat_en) begin
              state_d  = ST_DELAY;
              rp_cnt_d = RP_ZERO;
            end else if (rp_cnt_q == RR_LAST) begin
              pulse_d  = 1'b1;
              rp_cnt_d = RP_ZERO;
            end else begin
              rp_cnt_d = rp_cnt_q + RP_ONE;
            end
          end
          default: begin
            state_d  = ST_IDLE;
            rp_cnt_d = RP_ZERO;
          end
        endcase
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q <= DB_ZERO;
        level_q  <= 1'b0;
        state_q  <= ST_IDLE;
        rp_cnt_q <= RP_ZERO;
        pulse_q  <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        level_q  <= level_d;
        state_q  <= state_d;
        rp_cnt_q <= rp_cnt_d;
        pulse_q  <= pulse_d;
      end
    end

    assign level_vec_s[g] = level_q;
    assign pulse_vec_s[g] = pulse_q;
  end

  assign bus.btn_level = level_vec_s;
  assign bus.btn_pulse = pulse_vec_s;

endmodule

// File: tb/tb_button_repeat_conditioner.sv
// Bench for button_repeat_conditioner: directed vector table, reset sequence,
// and random stimulus against a window/elapsed-time reference model.
module tb_button_repeat_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  button_repeat_conditioner_if #(.N_BTN(N)) bus ();

  button_repeat_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: level flips when the last DB synced samples all disagree;
  // pulses come from elapsed enabled cycles since the press or re-arm.
  logic [DB+1:0] m_hist [N];
  int            m_t    [N];
  logic [N-1:0]  m_level;
  logic [N-1:0]  m_pulse;

  typedef struct packed {
    logic [3:0]      btn;
    logic            en;
    logic [7:0]      ncyc;
    logic [3:0]      exp_level;
    logic [3:0]      exp_last;
    logic [3:0][7:0] exp_cnt;
  } vec_t;

  localparam int NREC = 27;
  vec_t tbl [NREC];

  logic [N-1:0] tgt;
  logic         en_r;

  function automatic vec_t mk(input logic [3:0] b, input logic en, input int n,
                              input logic [3:0] lv, input logic [3:0] lp,
                              input int c0, input int c1, input int c2, input int c3);
    vec_t v;
    v.btn       = b;
    v.en        = en;
    v.ncyc      = 8'(n);
    v.exp_level = lv;
    v.exp_last  = lp;
    v.exp_cnt   = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    return v;
  endfunction

  task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < N; ch++) begin
      m_hist[ch] = '0;
      m_t[ch]    = 0;
    end
    m_level = '0;
    m_pulse = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] b, input logic en);
    for (int ch = 0; ch < N; ch++) begin
      logic all_diff;
      logic nl;
      m_hist[ch] = {m_hist[ch][DB:0], b[ch]};
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++) begin
        if (m_hist[ch][j] == m_level[ch]) all_diff = 1'b0;
      end
      nl = all_diff ? ~m_level[ch] : m_level[ch];
      m_pulse[ch] = 1'b0;
      if (!m_level[ch] && nl) begin
        m_pulse[ch] = 1'b1;
        m_t[ch]     = 0;
      end else if (m_level[ch] && nl) begin
        if (!en) begin
          m_t[ch] = 0;
        end else begin
          m_t[ch]++;
          m_pulse[ch] = (m_t[ch] == RD) || (m_t[ch] > RD && ((m_t[ch] - RD) % RR) == 0);
        end
      end
      m_level[ch] = nl;
    end
  endtask

  task automatic step(input logic [N-1:0] b, input logic en);
    bus.btn_in    = b;
    bus.repeat_en = en;
    @(posedge clk);
    if (rst_n) model_edge(b, en);
    #1;
    check_vec("model_level", bus.btn_level, m_level);
    check_vec("model_pulse", bus.btn_pulse, m_pulse);
  endtask

  task automatic do_reset(input logic [N-1:0] b, input logic en);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_vec("rst_async_level", bus.btn_level, {N{1'b0}});
    check_vec("rst_async_pulse", bus.btn_pulse, {N{1'b0}});
    step(b, en);
    rst_n = 1'b1;
  endtask

  task automatic run_hand(input string name, input logic [N-1:0] b, input int n,
                          input int exp_cnt, input logic [N-1:0] exp_lvl, input logic [N-1:0] exp_last);
    int cnt;
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      step(b, 1'b1);
      if (bus.btn_pulse[3]) cnt++;
    end
    check_int({name, "_cnt"}, cnt, exp_cnt);
    check_vec({name, "_level"}, bus.btn_level, exp_lvl);
    check_vec({name, "_last"}, bus.btn_pulse, exp_last);
  endtask

  initial begin
    tbl[0]  = mk(4'b0000, 1'b1,   5, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[1]  = mk(4'b0001, 1'b1,   5, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[2]  = mk(4'b0001, 1'b1,   1, 4'b0001, 4'b0001, 1, 0, 0, 0);
    tbl[3]  = mk(4'b0001, 1'b1,  19, 4'b0001, 4'b0000, 0, 0, 0, 0);
    tbl[4]  = mk(4'b0001, 1'b1,   1, 4'b0001, 4'b0001, 1, 0, 0, 0);
    tbl[5]  = mk(4'b0001, 1'b1,   8, 4'b0001, 4'b0001, 1, 0, 0, 0);
    tbl[6]  = mk(4'b0001, 1'b1,  16, 4'b0001, 4'b0001, 2, 0, 0, 0);
    tbl[7]  = mk(4'b0000, 1'b1,   5, 4'b0001, 4'b0000, 0, 0, 0, 0);
    tbl[8]  = mk(4'b0000, 1'b1,   1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[9]  = mk(4'b0100, 1'b1,   3, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[10] = mk(4'b0000, 1'b1,  10, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[11] = mk(4'b1000, 1'b1,   1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[12] = mk(4'b0000, 1'b1,   1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[13] = mk(4'b1000, 1'b1,   1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[14] = mk(4'b0000, 1'b1,   1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[15] = mk(4'b1000, 1'b1,   5, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[16] = mk(4'b1000, 1'b1,   1, 4'b1000, 4'b1000, 0, 0, 0, 1);
    tbl[17] = mk(4'b0000, 1'b1,   8, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[18] = mk(4'b0010, 1'b0, 100, 4'b0010, 4'b0000, 0, 1, 0, 0);
    tbl[19] = mk(4'b0010, 1'b1,  19, 4'b0010, 4'b0000, 0, 0, 0, 0);
    tbl[20] = mk(4'b0010, 1'b1,   1, 4'b0010, 4'b0010, 0, 1, 0, 0);
    tbl[21] = mk(4'b0000, 1'b1,   8, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[22] = mk(4'b1001, 1'b1,   6, 4'b1001, 4'b1001, 1, 0, 0, 1);
    tbl[23] = mk(4'b1001, 1'b1,  24, 4'b1001, 4'b0000, 1, 0, 0, 1);
    tbl[24] = mk(4'b1000, 1'b1,   5, 4'b1001, 4'b0000, 1, 0, 0, 1);
    tbl[25] = mk(4'b1000, 1'b1,   1, 4'b1000, 4'b0000, 0, 0, 0, 0);
    tbl[26] = mk(4'b1000, 1'b1,   8, 4'b1000, 4'b0000, 0, 0, 0, 1);

    rst_n         = 1'b0;
    bus.btn_in    = '0;
    bus.repeat_en = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_level", bus.btn_level, {N{1'b0}});
    check_vec("reset_pulse", bus.btn_pulse, {N{1'b0}});
    rst_n = 1'b1;

    for (int r = 0; r < NREC; r++) begin
      int cnt [N];
      for (int ch = 0; ch < N; ch++) cnt[ch] = 0;
      for (int c = 0; c < int'(tbl[r].ncyc); c++) begin
        step(tbl[r].btn, tbl[r].en);
        for (int ch = 0; ch < N; ch++) begin
          if (bus.btn_pulse[ch]) cnt[ch]++;
        end
      end
      check_vec($sformatf("tbl%0d_level", r), bus.btn_level, tbl[r].exp_level);
      check_vec($sformatf("tbl%0d_last_pulse", r), bus.btn_pulse, tbl[r].exp_last);
      for (int ch = 0; ch < N; ch++) begin
        check_int($sformatf("tbl%0d_cnt%0d", r, ch), cnt[ch], int'(tbl[r].exp_cnt[ch]));
      end
    end

    // Button R still held in REPEAT: reset for one edge, then a fresh press.
    do_reset(4'b1000, 1'b1);
    run_hand("rst_wait", 4'b1000,  5, 0, 4'b0000, 4'b0000);
    run_hand("rst_press", 4'b1000, 1, 1, 4'b1000, 4'b1000);
    run_hand("rst_delay", 4'b1000, 19, 0, 4'b1000, 4'b0000);
    run_hand("rst_rep1", 4'b1000,  1, 1, 4'b1000, 4'b1000);
    run_hand("rst_rep2", 4'b1000,  8, 1, 4'b1000, 4'b1000);

    tgt  = 4'b0000;
    en_r = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] drv;
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(59, 0) == 0) tgt[ch] = ~tgt[ch];
      end
      drv = tgt;
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(24, 0) == 0) drv[ch] = ~drv[ch];
      end
      if ($urandom_range(149, 0) == 0) en_r = ~en_r;
      if (c == 2000 || $urandom_range(1499, 0) == 0) do_reset(drv, en_r);
      else step(drv, en_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
